// File: rtl/pll_phase_pkg.sv
// Shared types and widths for the PLL phase-step arbiter.
package pll_phase_pkg;

  localparam int CNTSEL_W       = 5;
  localparam int STEPS_W        = 3;
  localparam int MAX_CNTSEL_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_PULSE     = 3'd2,
    ST_WAIT_LOW  = 3'd3,
    ST_WAIT_HIGH = 3'd4,
    ST_DONE      = 3'd5,
    ST_GAP       = 3'd6
  } state_t;

endpackage

// File: rtl/pll_phase_rr_arb.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module pll_phase_rr_arb #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  int               w_pos;
  logic [PTR_W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    w_j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      w_j = PTR_W'(w_pos);
      if (!o_valid && i_req[w_j]) begin
        o_valid      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/pll_phase_step_arbiter.sv
// Shares the PLL dynamic phase-shift port between N_REQ requesters, round-robin.
// Optional phase_done watchdog: define PLL_PHASE_TIMEOUT_EN.
module pll_phase_step_arbiter
  import pll_phase_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int EN_CYCLES      = 2,
  parameter int MAX_CNTSEL     = MAX_CNTSEL_DEF,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [CNTSEL_W*N_REQ-1:0] cntsel_i,
  input  logic [N_REQ-1:0]          updn_i,
  input  logic [STEPS_W*N_REQ-1:0]  steps_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic [N_REQ-1:0]          err_o,
  output logic                      busy_o,
  input  logic                      pll_locked_i,
  output logic                      pll_phase_en_o,
  output logic                      pll_updn_o,
  output logic [CNTSEL_W-1:0]       pll_cntsel_o,
  output logic [STEPS_W-1:0]        pll_num_shifts_o,
  input  logic                      pll_phase_done_i
);

  localparam int               PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] EN_LOAD  = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_t               r_state;
  logic [PTR_W-1:0]     r_ptr;
  logic [N_REQ-1:0]     r_grant;
  logic [CNTSEL_W-1:0]  r_cntsel;
  logic [STEPS_W-1:0]   r_steps;
  logic                 r_updn;
  logic [CNT_W-1:0]     r_cnt;
  logic [N_REQ-1:0]     r_ack;
  logic [N_REQ-1:0]     r_err;
  logic                 r_lock_s1, r_lock_s2;
  logic                 r_done_s1, r_done_s2;

  logic [N_REQ-1:0]     w_grant;
  logic [PTR_W-1:0]     w_idx;
  logic                 w_valid;
  logic [PTR_W-1:0]     w_ptr_next;
  logic [CNTSEL_W-1:0]  w_sel_cntsel;
  logic [STEPS_W-1:0]   w_sel_steps;
  logic                 w_sel_updn;
  logic                 w_illegal;
  logic                 w_waiting;
  logic                 w_tmo_hit;
  logic                 w_abort;
  logic                 w_drive;

  pll_phase_rr_arb #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_comb begin
    w_sel_cntsel = '0;
    w_sel_steps  = '0;
    w_sel_updn   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_cntsel = cntsel_i[k*CNTSEL_W +: CNTSEL_W];
        w_sel_steps  = steps_i[k*STEPS_W +: STEPS_W];
        w_sel_updn   = updn_i[k];
      end
    end
  end

  assign w_illegal  = (w_sel_steps == '0) || (int'(w_sel_cntsel) > MAX_CNTSEL);
  assign w_ptr_next = (int'(w_idx) >= N_REQ - 1) ? '0 : w_idx + 1'b1;
  assign w_waiting  = (r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HIGH);

`ifdef PLL_PHASE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                      r_tmo <= '0;
    else if (r_state == ST_PULSE)      r_tmo <= TMO_W'(TIMEOUT_CYCLES - 1);
    else if (w_waiting && r_tmo != '0) r_tmo <= r_tmo - 1'b1;
  end

  assign w_tmo_hit = w_waiting && (r_tmo == '0);
`else
  // Never fires: the limit is non-negative and no watchdog is built.
  assign w_tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Lock loss while the PLL is being driven (or the watchdog) ends the transaction with err.
  assign w_abort = ((r_state == ST_PULSE) || w_waiting) && (!r_lock_s2 || w_tmo_hit);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_cntsel  <= '0;
      r_steps   <= '0;
      r_updn    <= 1'b0;
      r_cnt     <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_done_s1 <= 1'b0;
      r_done_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= pll_locked_i;
      r_lock_s2 <= r_lock_s1;
      r_done_s1 <= pll_phase_done_i;
      r_done_s2 <= r_done_s1;
      r_ack     <= '0;
      r_err     <= '0;
      if (w_abort) begin
        r_ack   <= r_grant;
        r_err   <= r_grant;
        r_state <= ST_GAP;
        r_cnt   <= GAP_LOAD;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_lock_s2 && w_valid) begin
              r_grant  <= w_grant;
              r_cntsel <= w_sel_cntsel;
              r_steps  <= w_sel_steps;
              r_updn   <= w_sel_updn;
              r_ptr    <= w_ptr_next;
              if (w_illegal) begin
                r_ack   <= w_grant;
                r_err   <= w_grant;
                r_state <= ST_GAP;
                r_cnt   <= GAP_LOAD;
              end else begin
                r_state <= ST_SETUP;
              end
            end
          end
          ST_SETUP: begin
            r_state <= ST_PULSE;
            r_cnt   <= EN_LOAD;
          end
          ST_PULSE: begin
            if (r_cnt == '0) r_state <= ST_WAIT_LOW;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          ST_WAIT_LOW: begin
            if (!r_done_s2) r_state <= ST_WAIT_HIGH;
          end
          ST_WAIT_HIGH: begin
            if (r_done_s2) begin
              r_state <= ST_DONE;
              r_ack   <= r_grant;
            end
          end
          ST_DONE: begin
            r_state <= ST_GAP;
            r_cnt   <= GAP_LOAD;
          end
          ST_GAP: begin
            if (r_cnt == '0) r_state <= ST_IDLE;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_drive = r_state inside {ST_SETUP, ST_PULSE, ST_WAIT_LOW, ST_WAIT_HIGH, ST_DONE};

  assign ack_o            = r_ack;
  assign err_o            = r_err;
  assign busy_o           = (r_state != ST_IDLE);
  assign pll_phase_en_o   = (r_state == ST_PULSE) && r_lock_s2;
  assign pll_updn_o       = w_drive && r_updn;
  assign pll_cntsel_o     = w_drive ? r_cntsel : '0;
  assign pll_num_shifts_o = w_drive ? r_steps  : '0;

endmodule

// File: tb/tb_pll_phase_step_arbiter.sv
// Bench for pll_phase_step_arbiter: directed checks plus randomized traffic against a cycle model.
module tb_pll_phase_step_arbiter;

  localparam int N    = 4;
  localparam int EN   = 2;
  localparam int MAXC = 8;
  localparam int GAP  = 2;
  localparam int TMO  = 16;
`ifdef PLL_PHASE_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  localparam int P_IDLE = 0, P_SETUP = 1, P_PULSE = 2, P_WL = 3, P_WH = 4, P_DONE = 5, P_GAP = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  req;
  logic [5*N-1:0] cntsel;
  logic [N-1:0]  updn;
  logic [3*N-1:0] steps;
  logic          lock;
  logic          done;
  logic [N-1:0]  ack_o, err_o;
  logic          busy_o, pll_phase_en_o, pll_updn_o;
  logic [4:0]    pll_cntsel_o;
  logic [2:0]    pll_num_shifts_o;

  pll_phase_step_arbiter #(
    .N_REQ(N), .EN_CYCLES(EN), .MAX_CNTSEL(MAXC), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .cntsel_i(cntsel), .updn_i(updn),
    .steps_i(steps), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o),
    .pll_locked_i(lock), .pll_phase_en_o(pll_phase_en_o), .pll_updn_o(pll_updn_o),
    .pll_cntsel_o(pll_cntsel_o), .pll_num_shifts_o(pll_num_shifts_o),
    .pll_phase_done_i(done)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase = P_IDLE, m_left = 0, m_wait = 0, m_who = 0, m_ptr = 0;
  int m_cs = 0, m_st = 0, m_ud = 0;
  bit m_fail = 1'b0;
  bit m_lk0 = 1'b0, m_lk1 = 1'b0, m_dn0 = 1'b0, m_dn1 = 1'b0;

  task automatic model_abort();
    m_fail  = 1'b1;
    m_phase = P_GAP;
    m_left  = GAP;
  endtask

  task automatic model_step();
    int g;
    bit lk, dn;
    lk = m_lk1;
    dn = m_dn1;
    m_fail = 1'b0;
    if (!rst_n) begin
      m_phase = P_IDLE; m_ptr = 0;
      m_lk0 = 0; m_lk1 = 0; m_dn0 = 0; m_dn1 = 0;
      return;
    end
    case (m_phase)
      P_IDLE: if (lk && req != 0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && ((int'(req) >> ((m_ptr + k) % N)) & 1) == 1) g = (m_ptr + k) % N;
        m_who = g;
        m_cs  = int'(cntsel >> (5 * g)) & 31;
        m_st  = int'(steps >> (3 * g)) & 7;
        m_ud  = int'(updn >> g) & 1;
        m_ptr = (g + 1) % N;
        if (m_st == 0 || m_cs > MAXC) model_abort();
        else m_phase = P_SETUP;
      end
      P_SETUP: begin m_phase = P_PULSE; m_left = EN; end
      P_PULSE: begin
        if (!lk) model_abort();
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = P_WL; m_wait = 0; end
        end
      end
      P_WL, P_WH: begin
        m_wait++;
        if (!lk) model_abort();
        else if (TMO_ON && m_wait == TMO) model_abort();
        else if (m_phase == P_WL && !dn) m_phase = P_WH;
        else if (m_phase == P_WH && dn) m_phase = P_DONE;
      end
      P_DONE: begin m_phase = P_GAP; m_left = GAP; end
      P_GAP: begin
        m_left--;
        if (m_left == 0) m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
    m_lk1 = m_lk0; m_lk0 = lock;
    m_dn1 = m_dn0; m_dn0 = done;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    bit drive;
    int e_ack, e_err;
    @(negedge clk);
    if (chk_en) begin
      drive = (m_phase >= P_SETUP && m_phase <= P_DONE);
      e_ack = (m_phase == P_DONE || m_fail) ? (1 << m_who) : 0;
      e_err = m_fail ? (1 << m_who) : 0;
      check("ack_o",      32'(ack_o),            32'(e_ack));
      check("err_o",      32'(err_o),            32'(e_err));
      check("busy_o",     32'(busy_o),           32'(m_phase != P_IDLE));
      check("phase_en",   32'(pll_phase_en_o),   32'(m_phase == P_PULSE && m_lk1));
      check("pll_updn",   32'(pll_updn_o),       drive ? 32'(m_ud) : 32'd0);
      check("pll_cntsel", 32'(pll_cntsel_o),     drive ? 32'(m_cs) : 32'd0);
      check("pll_shifts", 32'(pll_num_shifts_o), drive ? 32'(m_st) : 32'd0);
    end
  end

  // ---------------- PLL phase_done model ----------------
  bit pll_auto = 1'b1;
  bit pll_force_done = 1'b1;

  initial begin
    bit prev_en;
    int dly, low_left;
    prev_en = 0; dly = -1; low_left = 0;
    done = 1'b1;
    forever begin
      @(negedge clk);
      if (!pll_auto) begin
        done = pll_force_done;
        dly = -1;
      end else begin
        if (prev_en && !pll_phase_en_o) begin
          dly = $urandom_range(0, 2);
          low_left = $urandom_range(1, 5);
        end
        if (dly > 0) dly--;
        else if (dly == 0) begin
          if (low_left > 0) begin done = 1'b0; low_left--; end
          else begin done = 1'b1; dly = -1; end
        end
      end
      prev_en = pll_phase_en_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input int cs, input int ud, input int st);
    logic [4:0] c5;
    logic [2:0] s3;
    c5 = 5'(cs);
    s3 = 3'(st);
    cntsel[5*k +: 5] = c5;
    steps[3*k +: 3]  = s3;
    updn[k]          = ud[0];
  endtask

  task automatic wait_ack(input int k, input int limit, output bit got, output int cyc);
    got = 0;
    for (cyc = 1; cyc <= limit; cyc++) begin
      tick();
      if (ack_o[k]) begin got = 1; break; end
    end
  endtask

  task automatic wait_en_fall(input int limit, output bit got);
    bit hi;
    hi = 0; got = 0;
    for (int c = 0; c < limit; c++) begin
      tick();
      if (pll_phase_en_o) hi = 1;
      else if (hi) begin got = 1; break; end
    end
  endtask

  initial begin
    int en_cnt, ack_cnt, n, cyc, bad, lock_low_left;
    int order[5];
    logic [4:0] seen_cs;
    logic [2:0] seen_sh;
    bit got, err_seen;

    rst_n = 0; req = '0; cntsel = '0; updn = '0; steps = '0; lock = 0;
    repeat (3) tick();
    chk_en = 1;
    check("rst_busy",   32'(busy_o), 0);
    check("rst_en",     32'(pll_phase_en_o), 0);
    check("rst_ack",    32'(ack_o), 0);
    check("rst_cntsel", 32'(pll_cntsel_o), 0);
    check("rst_shifts", 32'(pll_num_shifts_o), 0);
    rst_n = 1; lock = 1;
    repeat (4) tick();

    // single legal transaction on requester 1
    set_req(1, 3, 1, 5); req[1] = 1;
    en_cnt = 0; ack_cnt = 0; err_seen = 0; seen_cs = 0; seen_sh = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      tick();
      if (pll_phase_en_o) en_cnt++;
      if (pll_cntsel_o != 0 && seen_cs == 0) begin seen_cs = pll_cntsel_o; seen_sh = pll_num_shifts_o; end
      if (ack_o[1]) begin got = 1; ack_cnt++; err_seen = err_o[1]; req[1] = 0; end
    end
    repeat (5) begin tick(); if (ack_o[1]) ack_cnt++; end
    check("t1_ack_seen", 32'(got), 1);
    check("t1_cntsel",   32'(seen_cs), 3);
    check("t1_shifts",   32'(seen_sh), 5);
    check("t1_en_len",   32'(en_cnt), 2);
    check("t1_ack_once", 32'(ack_cnt), 1);
    check("t1_err",      32'(err_seen), 0);

    // all four requesting continuously: round-robin order from pointer 0
    rst_n = 0; tick(); rst_n = 1; repeat (3) tick();
    for (int k = 0; k < N; k++) set_req(k, k + 1, k % 2, k + 1);
    req = 4'hF;
    n = 0;
    for (int c = 0; c < 400 && n < 5; c++) begin
      tick();
      if (ack_o != 0) begin
        check("t2_onehot", 32'($onehot(ack_o)), 1);
        for (int k = 0; k < N; k++) if (ack_o[k]) order[n] = k;
        n++;
      end
    end
    req = '0;
    check("t2_ack_count", 32'(n), 5);
    for (int i = 0; i < n; i++) check("t2_order", 32'(order[i]), 32'(i % N));

    // illegal requests: steps 0, then cntsel above the limit
    repeat (6) tick();
    en_cnt = 0;
    set_req(2, 4, 0, 0); req[2] = 1;
    wait_ack(2, 20, got, cyc);
    check("t3a_ack", 32'(got), 1);
    check("t3a_err", 32'(err_o[2]), 1);
    req[2] = 0;
    repeat (4) begin tick(); if (pll_phase_en_o) en_cnt++; end
    set_req(0, 9, 1, 3); req[0] = 1;
    wait_ack(0, 20, got, cyc);
    check("t3b_ack", 32'(got), 1);
    check("t3b_err", 32'(err_o[0]), 1);
    req[0] = 0;
    repeat (4) begin tick(); if (pll_phase_en_o) en_cnt++; end
    check("t3_no_en", 32'(en_cnt), 0);

    // unlocked: no grant; after lock rises the grant lands 3 edges later
    lock = 0; repeat (4) tick();
    set_req(3, 2, 1, 2); req[3] = 1;
    bad = 0;
    repeat (10) begin tick(); if (busy_o) bad++; end
    check("t4_busy_unlocked", 32'(bad), 0);
    lock = 1; cyc = 0;
    for (int c = 1; c <= 10; c++) begin tick(); if (busy_o) begin cyc = c; break; end end
    check("t4_start_latency", 32'(cyc), 3);
    wait_ack(3, 60, got, cyc);
    check("t4_ack", 32'(got), 1);
    check("t4_err", 32'(err_o[3]), 0);
    req[3] = 0;

    // lock lost while waiting for phase_done to return high
    repeat (4) tick();
    pll_auto = 0; pll_force_done = 1;
    set_req(1, 5, 0, 4); req[1] = 1;
    wait_en_fall(20, got);
    check("t5a_pulse", 32'(got), 1);
    pll_force_done = 0;
    repeat (5) tick();
    lock = 0;
    wait_ack(1, 10, got, cyc);
    check("t5a_ack", 32'(got), 1);
    check("t5a_err", 32'(err_o[1]), 1);
    check("t5a_en",  32'(pll_phase_en_o), 0);
    req[1] = 0; pll_force_done = 1; lock = 1;
    repeat (6) tick();

    // reset while phase_en is high
    pll_auto = 1;
    set_req(2, 1, 1, 1); req[2] = 1;
    got = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (pll_phase_en_o) begin got = 1; break; end end
    check("t5b_pulse", 32'(got), 1);
    rst_n = 0; req = '0;
    tick();
    check("t5b_en",     32'(pll_phase_en_o), 0);
    check("t5b_busy",   32'(busy_o), 0);
    check("t5b_cntsel", 32'(pll_cntsel_o), 0);
    rst_n = 1;
    ack_cnt = 0;
    repeat (10) begin tick(); if (ack_o != 0) ack_cnt++; end
    check("t5b_no_ack", 32'(ack_cnt), 0);

    // phase_done never falls
    pll_auto = 0; pll_force_done = 1;
    set_req(0, 2, 0, 2); req[0] = 1;
    wait_en_fall(20, got);
    check("t6_pulse", 32'(got), 1);
`ifdef PLL_PHASE_TIMEOUT_EN
    wait_ack(0, TMO + 10, got, cyc);
    check("t6_tmo_ack", 32'(got), 1);
    check("t6_tmo_cyc", 32'(cyc), TMO);
    check("t6_tmo_err", 32'(err_o[0]), 1);
`else
    bad = 0;
    repeat (40) begin tick(); if (!busy_o || ack_o != 0) bad++; end
    check("t6_stuck_busy", 32'(bad), 0);
`endif
    req[0] = 0; pll_auto = 1;
    rst_n = 0; tick(); rst_n = 1; repeat (3) tick();

    // randomized traffic with lock drops and occasional resets
    lock_low_left = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      if (lock_low_left > 0) begin
        lock_low_left--;
        lock = (lock_low_left == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        lock = 0;
        lock_low_left = $urandom_range(2, 12);
      end
      for (int k = 0; k < N; k++) begin
        if (req[k] && ack_o[k]) begin
          if ($urandom_range(0, 1) == 0) req[k] = 0;
          else set_req(k, $urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 7));
        end else if (!req[k] && $urandom_range(0, 5) == 0) begin
          set_req(k, $urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 7));
          req[k] = 1;
        end else if (req[k] && $urandom_range(0, 99) == 0) begin
          req[k] = 0;
        end
      end
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
